// File: rtl/crypto_wallet_cpu_cpu_ocimem_arbiter.sv
// OCI debug-memory arbiter: runs JTAG monitor commands against the single-port
// debug RAM and lends the RAM to the CPU's Avalon debug_mem_slave when JTAG is quiet.
module crypto_wallet_cpu_cpu_ocimem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  typedef enum logic [1:0] {IDLE, AV_RD, JT_RD, JT_WR} state_t;

  localparam logic [1:0]        LP_LAT = 2'(RAM_RD_LAT);
  localparam logic [ADDR_W-1:0] LP_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_run;
  logic              r_pend;
  logic              r_pend_wr;
  logic              r_pend_inc;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [31:0]       r_pend_data;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic              r_ready;
  logic              r_error;
  logic              r_ack;

  logic              w_strobe;
  logic              w_new_op;
  logic              w_accept;
  logic              w_jt_any;
  logic              w_jt_wr;
  logic              w_rd_done;
  logic              w_av_wr;
  logic              w_av_rd_go;
  logic [ADDR_W-1:0] w_jdo_addr;
  logic              w_unused;

  assign w_jdo_addr = jdo[ADDR_W+16:17];
  assign w_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_new_op   = (take_action_ocimem_a & jdo[34]) | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_accept   = w_new_op & ~r_pend;
  // A strobe arriving this cycle already outranks Avalon, so JTAG wins a same-cycle tie.
  assign w_jt_any   = r_pend | w_accept;
  assign w_jt_wr    = r_pend ? r_pend_wr : take_action_ocimem_b;
  assign w_rd_done  = (r_cnt == LP_LAT);
  assign w_av_wr    = r_run & (r_state == IDLE) & ~w_jt_any & avs_write;
  assign w_av_rd_go = r_run & (r_state == IDLE) & ~w_jt_any & ~avs_write & avs_read;
  assign w_unused   = ^{jdo[37:35], jdo[2:0]};

  assign MonAReg       = r_mon_a;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

  always_comb begin
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_byteen      = '0;
    ram_wdata       = '0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    case (r_state)
      IDLE: begin
        if (w_av_wr) begin
          ram_addr        = avs_address;
          ram_wren        = 1'b1;
          ram_byteen      = avs_byteenable;
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
        end
      end
      AV_RD: begin
        ram_addr = avs_address;
        if (w_rd_done) begin
          avs_waitrequest = 1'b0;
          avs_readdata    = ram_rdata;
        end
      end
      JT_RD: ram_addr = r_pend_addr;
      JT_WR: begin
        ram_addr   = r_pend_addr;
        ram_wren   = 1'b1;
        ram_byteen = 4'hF;
        ram_wdata  = r_pend_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_run       <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_wr   <= 1'b0;
      r_pend_inc  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_mon_a     <= '0;
      r_mon_d     <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // Address-only loads acknowledge one cycle after the strobe so ready shows a fresh edge.
      r_ack <= take_action_ocimem_a & ~jdo[34] & ~r_pend;
      if (r_ack)
        r_ready <= 1'b1;
      if (w_strobe)
        r_ready <= 1'b0;
      if (w_strobe & r_pend)
        r_error <= 1'b1;
      if (take_action_ocimem_a)
        r_mon_a <= w_jdo_addr;
      if (w_accept) begin
        r_pend      <= 1'b1;
        r_pend_wr   <= take_action_ocimem_b;
        r_pend_inc  <= take_no_action_ocimem_a;
        r_pend_addr <= take_action_ocimem_a ? w_jdo_addr : r_mon_a;
        r_pend_data <= jdo[34:3];
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_jt_any)
            r_state <= w_jt_wr ? JT_WR : JT_RD;
          else if (w_av_rd_go)
            r_state <= AV_RD;
        end
        AV_RD: begin
          if (w_rd_done) begin
            r_cnt   <= '0;
            r_state <= w_jt_any ? (w_jt_wr ? JT_WR : JT_RD) : IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        JT_RD: begin
          if (w_rd_done) begin
            r_cnt   <= '0;
            r_mon_d <= ram_rdata;
            if (r_pend_inc)
              r_mon_a <= r_pend_addr + LP_ONE;
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        JT_WR: begin
          r_mon_a <= r_pend_addr + LP_ONE;
          r_pend  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
